// File: rtl/vwb_sequencer_if.sv
// Vector writeback sequencer bus: command handshake, result beat handshake,
// old-destination read port and register file write port.
// master = command/result source side, slave = the sequencer.
interface vwb_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_wa;
    logic [2:0]  cmd_sew;
    logic [2:0]  cmd_lmul;
    logic [7:0]  cmd_vl;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [4:0]  ra_old;
    logic [63:0] rd_old;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        wen;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output cmd_valid, cmd_wa, cmd_sew, cmd_lmul, cmd_vl,
               res_valid, res_data, rd_old,
        input  cmd_ready, res_ready, ra_old, wa, wd, wen, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_wa, cmd_sew, cmd_lmul, cmd_vl,
               res_valid, res_data, rd_old,
        output cmd_ready, res_ready, ra_old, wa, wd, wen, busy, done, err
    );
endinterface

// File: rtl/vwb_sequencer.sv
// Vector writeback sequencer: accepts one writeback command, then writes one
// 64-bit beat per register of the LMUL group, replacing tail elements.
// Optional feature macro: VWB_TAIL_UNDISTURBED_EN
//   defined   -> tail elements keep the old register contents (rd_old)
//   undefined -> tail elements are written all-ones, ra_old tied to 0
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WRITE | consuming result beats, one register write per beat
// DONE  | one-cycle done pulse (err marks a rejected command)
module vwb_sequencer #(
    parameter int VLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    vwb_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  base_q, base_d;
    logic [1:0]  sew_q, sew_d;
    logic [1:0]  lsh_q, lsh_d;
    logic [2:0]  beat_q, beat_d;
    logic [7:0]  vl_q, vl_d;
    logic        err_q, err_d;
    logic [4:0]  wa_q, wa_d;
    logic [63:0] wd_q, wd_d;
    logic        wen_q, wen_d;

    logic [1:0]  cmd_lsh;
    logic [3:0]  cmd_nregs;
    logic [7:0]  cmd_vlmax;
    logic        cmd_bad;
    logic [4:0]  target;
    logic [2:0]  nregs_m1;
    logic [63:0] tail_data;
    logic [63:0] merged;

    // Command decode: fractional LMUL collapses to a single register
    always_comb begin
        cmd_lsh   = bus.cmd_lmul[2] ? 2'd0 : bus.cmd_lmul[1:0];
        cmd_nregs = 4'd1 << cmd_lsh;
        cmd_vlmax = (8'd8 >> bus.cmd_sew[1:0]) << cmd_lsh;
        cmd_bad   = bus.cmd_sew[2] | (bus.cmd_lmul == 3'd4) |
                    ((bus.cmd_wa & {1'b0, cmd_nregs - 4'd1}) != 5'd0);
    end

    assign target   = base_q + {2'b00, beat_q};
    assign nregs_m1 = {lsh_q == 2'd3, lsh_q >= 2'd2, lsh_q >= 2'd1};

`ifdef VWB_TAIL_UNDISTURBED_EN
    assign tail_data  = bus.rd_old;
    assign bus.ra_old = target;
`else
    logic unused_rd_old;
    assign unused_rd_old = ^bus.rd_old;
    assign tail_data     = '1;
    assign bus.ra_old    = 5'd0;
`endif

    // Per-byte body/tail merge; a byte is body when its element index < vl
    always_comb begin
        merged = '0;
        for (int j = 0; j < 8; j++) begin
            logic [7:0] idx;
            idx = ({5'd0, beat_q} << (2'd3 - sew_q)) + (8'(j) >> sew_q);
            merged[j*8 +: 8] = (idx < vl_q) ? bus.res_data[j*8 +: 8]
                                            : tail_data[j*8 +: 8];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        sew_d   = sew_q;
        lsh_d   = lsh_q;
        beat_d  = beat_q;
        vl_d    = vl_q;
        err_d   = err_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        wen_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    base_d  = bus.cmd_wa;
                    sew_d   = bus.cmd_sew[1:0];
                    lsh_d   = cmd_lsh;
                    beat_d  = 3'd0;
                    vl_d    = (bus.cmd_vl < cmd_vlmax) ? bus.cmd_vl : cmd_vlmax;
                    err_d   = cmd_bad;
                    state_d = cmd_bad ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (bus.res_valid) begin
                    wen_d  = 1'b1;
                    wa_d   = target;
                    wd_d   = merged;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == nregs_m1) state_d = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and write-port registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            sew_q   <= '0;
            lsh_q   <= '0;
            beat_q  <= '0;
            vl_q    <= '0;
            err_q   <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            sew_q   <= sew_d;
            lsh_q   <= lsh_d;
            beat_q  <= beat_d;
            vl_q    <= vl_d;
            err_q   <= err_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            wen_q   <= wen_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE) & rst_i;
    assign bus.res_ready = (state_q == WRITE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == DONE) & err_q;
    assign bus.wa        = wa_q;
    assign bus.wd        = wd_q;
    assign bus.wen       = wen_q;
endmodule

// File: tb/tb_vwb_sequencer.sv
// Directed bench for vwb_sequencer; tail expectations follow the build's
// VWB_TAIL_UNDISTURBED_EN setting.
module tb_vwb_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad   = 0;

`ifdef VWB_TAIL_UNDISTURBED_EN
    localparam logic [31:0] T32   = 32'hAAAA_AAAA;
    localparam logic [63:0] SEW8E = 64'hAAAA_AA44_5566_7788;
    localparam bit          TU    = 1'b1;
`else
    localparam logic [31:0] T32   = 32'hFFFF_FFFF;
    localparam logic [63:0] SEW8E = 64'hFFFF_FF44_5566_7788;
    localparam bit          TU    = 1'b0;
`endif

    vwb_sequencer_if bus ();

    vwb_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [4:0] wa, input logic [2:0] sew,
                             input logic [2:0] lmul, input logic [7:0] vl);
        bus.cmd_valid = 1'b1;
        bus.cmd_wa    = wa;
        bus.cmd_sew   = sew;
        bus.cmd_lmul  = lmul;
        bus.cmd_vl    = vl;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        total++;
        if ({bus.wen, bus.done, bus.err, bus.busy, bus.res_ready, bus.cmd_ready} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {bus.wen, bus.done, bus.err, bus.busy, bus.res_ready, bus.cmd_ready});
        end
        total++;
        if (bus.wa !== 5'd0 || bus.wd !== 64'd0) begin
            bad++;
            $display("FAIL reset_wport wa=%0d wd=%h want 0/0", bus.wa, bus.wd);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release cmd_ready=%b want=1", bus.cmd_ready);
        end
    endtask

    task automatic test_sew8();
        issue_cmd(5'd3, 3'd0, 3'd0, 8'd5);
        total++;
        if (bus.busy !== 1'b1 || bus.res_ready !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL sew8_accept busy=%b res_ready=%b cmd_ready=%b want 1/1/0",
                     bus.busy, bus.res_ready, bus.cmd_ready);
        end
        bus.res_valid = 1'b1;
        bus.res_data  = 64'h1122_3344_5566_7788;
        #1;
        total++;
        if (bus.ra_old !== (TU ? 5'd3 : 5'd0)) begin
            bad++;
            $display("FAIL sew8_ra_old got=%0d want=%0d", bus.ra_old, TU ? 3 : 0);
        end
        tick();
        bus.res_valid = 1'b0;
        total++;
        if (bus.wen !== 1'b1 || bus.wa !== 5'd3 || bus.wd !== SEW8E || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL sew8_write wen=%b wa=%0d wd=%h done=%b want 1/3/%h/1",
                     bus.wen, bus.wa, bus.wd, bus.done, SEW8E);
        end
        tick();
        total++;
        if (bus.wen !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL sew8_after wen=%b done=%b cmd_ready=%b want 0/0/1",
                     bus.wen, bus.done, bus.cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res_t [4];
        logic [63:0] exp_t [4];
        res_t[0] = 64'h0000_0002_0000_0001;
        res_t[1] = 64'h0000_0004_0000_0003;
        res_t[2] = 64'h0000_0006_0000_0005;
        res_t[3] = 64'h0000_0008_0000_0007;
        exp_t[0] = res_t[0];
        exp_t[1] = res_t[1];
        exp_t[2] = {T32, 32'h0000_0005};
        exp_t[3] = {T32, T32};
        issue_cmd(5'd8, 3'd2, 3'd2, 8'd5);
        bus.res_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.res_data = res_t[b];
            #1;
            total++;
            if (bus.ra_old !== (TU ? 5'(8 + b) : 5'd0)) begin
                bad++;
                $display("FAIL grp_ra_old beat=%0d got=%0d", b, bus.ra_old);
            end
            tick();
            total++;
            if (bus.wen !== 1'b1 || bus.wa !== 5'(8 + b) || bus.wd !== exp_t[b] ||
                bus.done !== (b == 3)) begin
                bad++;
                $display("FAIL grp_write beat=%0d wen=%b wa=%0d wd=%h done=%b want 1/%0d/%h/%0d",
                         b, bus.wen, bus.wa, bus.wd, bus.done, 8 + b, exp_t[b], b == 3);
            end
        end
        bus.res_valid = 1'b0;
        tick();
        total++;
        if (bus.wen !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL grp_end wen=%b done=%b busy=%b cmd_ready=%b want 0/0/0/1",
                     bus.wen, bus.done, bus.busy, bus.cmd_ready);
        end
    endtask

    task automatic test_reject(input logic [4:0] wa, input logic [2:0] sew,
                               input logic [2:0] lmul, input string name);
        issue_cmd(wa, sew, lmul, 8'd8);
        bus.res_valid = 1'b1;
        bus.res_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        total++;
        if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.wen !== 1'b0 || bus.res_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_done done=%b err=%b wen=%b res_ready=%b want 1/1/0/0",
                     name, bus.done, bus.err, bus.wen, bus.res_ready);
        end
        tick();
        bus.res_valid = 1'b0;
        total++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.wen !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_after done=%b err=%b wen=%b cmd_ready=%b want 0/0/0/1",
                     name, bus.done, bus.err, bus.wen, bus.cmd_ready);
        end
    endtask

    task automatic test_vl_clamp();
        issue_cmd(5'd4, 3'd3, 3'd0, 8'd200);
        bus.res_valid = 1'b1;
        bus.res_data  = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.res_valid = 1'b0;
        total++;
        if (bus.wen !== 1'b1 || bus.wa !== 5'd4 || bus.wd !== 64'h0123_4567_89AB_CDEF ||
            bus.done !== 1'b1 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL clamp_write wen=%b wa=%0d wd=%h done=%b err=%b want 1/4/0123456789abcdef/1/0",
                     bus.wen, bus.wa, bus.wd, bus.done, bus.err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        issue_cmd(5'd0, 3'd0, 3'd3, 8'd64);
        bus.res_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.res_data = 64'h0101_0101_0101_0101 * (b + 1);
            tick();
            total++;
            if (bus.wen !== 1'b1 || bus.wa !== 5'(b) || bus.wd !== 64'h0101_0101_0101_0101 * (b + 1)) begin
                bad++;
                $display("FAIL mid_beat beat=%0d wen=%b wa=%0d wd=%h", b, bus.wen, bus.wa, bus.wd);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.wen !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.wa !== 5'd0 || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset wen=%b busy=%b done=%b wa=%0d cmd_ready=%b want 0/0/0/0/0",
                     bus.wen, bus.busy, bus.done, bus.wa, bus.cmd_ready);
        end
        rst = 1'b1;
        bus.res_valid = 1'b0;
        #1;
        issue_cmd(5'd16, 3'd3, 3'd1, 8'd2);
        bus.res_valid = 1'b1;
        bus.res_data  = 64'h5555_0000_5555_0000;
        tick();
        total++;
        if (bus.wen !== 1'b1 || bus.wa !== 5'd16 || bus.wd !== 64'h5555_0000_5555_0000 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_b0 wen=%b wa=%0d wd=%h done=%b want 1/16/5555000055550000/0",
                     bus.wen, bus.wa, bus.wd, bus.done);
        end
        bus.res_data = 64'h0000_6666_0000_6666;
        tick();
        bus.res_valid = 1'b0;
        total++;
        if (bus.wen !== 1'b1 || bus.wa !== 5'd17 || bus.wd !== 64'h0000_6666_0000_6666 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_b1 wen=%b wa=%0d wd=%h done=%b want 1/17/0000666600006666/1",
                     bus.wen, bus.wa, bus.wd, bus.done);
        end
        tick();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_wa    = '0;
        bus.cmd_sew   = '0;
        bus.cmd_lmul  = '0;
        bus.cmd_vl    = '0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.rd_old    = 64'hAAAA_AAAA_AAAA_AAAA;
        test_reset();
        test_sew8();
        test_back_to_back();
        test_reject(5'd5, 3'd0, 3'd1, "align_err");
        test_reject(5'd0, 3'd5, 3'd0, "bad_sew");
        test_reject(5'd0, 3'd0, 3'd4, "bad_lmul");
        test_vl_clamp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
